// File: rtl/chess_pkg.sv
// Shared board encoding: piece numbers, colours, square type, initial placement
// and the square-query FSM states.
package chess_pkg;

  typedef logic [5:0] square_t;
  typedef logic [3:0] piece_t;

  localparam piece_t K1 = 4'd0;
  localparam piece_t Q1 = 4'd1;
  localparam piece_t R1 = 4'd2;
  localparam piece_t R2 = 4'd3;
  localparam piece_t B1 = 4'd4;
  localparam piece_t B2 = 4'd5;
  localparam piece_t N1 = 4'd6;
  localparam piece_t N2 = 4'd7;
  localparam piece_t P8 = 4'd8;
  localparam piece_t P7 = 4'd9;
  localparam piece_t P6 = 4'd10;
  localparam piece_t P5 = 4'd11;
  localparam piece_t P4 = 4'd12;
  localparam piece_t P3 = 4'd13;
  localparam piece_t P2 = 4'd14;
  localparam piece_t P1 = 4'd15;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  // Listed from piece 15 (P1) down to piece 0 (K1); square = rank*8 + file.
  localparam logic [95:0] INIT_LOC_W = {
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
    6'd6,  6'd1,  6'd5,  6'd2,  6'd7,  6'd0,  6'd3,  6'd4
  };
  localparam logic [95:0] INIT_LOC_B = {
    6'd48, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55,
    6'd62, 6'd57, 6'd61, 6'd58, 6'd63, 6'd56, 6'd59, 6'd60
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/piece_slot_mux.sv
// Selects one of the 32 piece slots by scan index: white P1..K1, then black P1..K1.
module piece_slot_mux
  import chess_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [95:0] location_vectors_w,
  input  logic [95:0] location_vectors_b,
  input  logic [15:0] alive_vectors_w,
  input  logic [15:0] alive_vectors_b,
  output square_t     slot_loc,
  output logic        slot_alive,
  output logic        slot_color,
  output piece_t      slot_piece
);

  // 15-idx for white and 31-idx for black both reduce to the inverted low nibble.
  assign slot_piece = ~idx[3:0];
  assign slot_color = idx[4] ? BLACK : WHITE;

  always_comb begin
    slot_loc   = '0;
    slot_alive = 1'b0;
    for (int unsigned p = 0; p < 16; p++) begin
      if (p[3:0] == slot_piece) begin
        slot_loc   = idx[4] ? location_vectors_b[6*p +: 6] : location_vectors_w[6*p +: 6];
        slot_alive = idx[4] ? alive_vectors_b[p] : alive_vectors_w[p];
      end
    end
  end

endmodule

// File: rtl/board_square_query.sv
// Square-to-piece lookup: scans the 32 piece slots one per cycle and reports
// the first live piece standing on the requested square.
module board_square_query
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        req,
  input  logic [5:0]  square,
  input  logic [95:0] location_vectors_w,
  input  logic [95:0] location_vectors_b,
  input  logic [15:0] alive_vectors_w,
  input  logic [15:0] alive_vectors_b,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        resp_color,
  output logic [3:0]  resp_piece
);

  state_t     state, state_nx;
  logic [4:0] idx, idx_nx;
  square_t    sq, sq_nx;
  logic       hit_nx, color_nx;
  piece_t     piece_nx;

  square_t    slot_loc;
  logic       slot_alive, slot_color;
  piece_t     slot_piece;

  piece_slot_mux u_mux (
    .idx                (idx),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .slot_loc           (slot_loc),
    .slot_alive         (slot_alive),
    .slot_color         (slot_color),
    .slot_piece         (slot_piece)
  );

  assign ready      = (state == IDLE);
  assign resp_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    sq_nx    = sq;
    hit_nx   = resp_hit;
    color_nx = resp_color;
    piece_nx = resp_piece;
    case (state)
      IDLE: begin
        if (req) begin
          sq_nx    = square;
          idx_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (slot_alive && (slot_loc == sq)) begin
          hit_nx   = 1'b1;
          color_nx = slot_color;
          piece_nx = slot_piece;
          state_nx = DONE;
        end else if (idx == 5'd31) begin
          hit_nx   = 1'b0;
          color_nx = 1'b0;
          piece_nx = '0;
          state_nx = DONE;
        end else begin
          idx_nx = idx + 5'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      sq         <= '0;
      resp_hit   <= 1'b0;
      resp_color <= 1'b0;
      resp_piece <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      sq         <= sq_nx;
      resp_hit   <= hit_nx;
      resp_color <= color_nx;
      resp_piece <= piece_nx;
    end
  end

endmodule
